// File: rtl/icache_line_fill_if.sv
// Handshake bundle for the instruction-cache line-fill engine.
// Line side: the cache requests a whole line and receives it assembled.
// Memory side: the engine issues one 32-bit word read per beat.
// Modport "slave" is the fill engine's view (it serves line requests and
// drives the memory requests); "master" is the cache/memory side view.
interface icache_line_fill_if #(
    parameter int LINE_BYTES = 8
);
    logic                    line_valid;
    logic                    line_ready;
    logic [31:0]             line_addr;
    logic [8*LINE_BYTES-1:0] line_rdata;
    logic                    mem_valid;
    logic                    mem_ready;
    logic [31:0]             mem_addr;
    logic [31:0]             mem_rdata;

    modport slave (
        input  line_valid,
        input  line_addr,
        output line_ready,
        output line_rdata,
        output mem_valid,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport master (
        output line_valid,
        output line_addr,
        input  line_ready,
        input  line_rdata,
        input  mem_valid,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/icache_line_fill.sv
// Instruction-cache line-fill engine.
// Accepts a line request, reads the line from memory one 32-bit word per
// beat (lowest address first), assembles it and returns it with a
// one-cycle line_ready pulse. Dropping line_valid mid-fill aborts the fill
// after the beat in flight completes.
// Optional feature macro: ICACHE_LINE_FILL_BUF_EN adds a one-entry
// last-line buffer; a request for the most recently completed line is
// answered from it without touching memory.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for line_valid; line_rdata holds the last line
// S_FETCH | mem_valid high, reading word beat_q at mem_addr
// S_DONE  | line_ready high for this single cycle, then back to IDLE
module icache_line_fill #(
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 2
) (
    input  logic              clk,
    input  logic              resetn,
    icache_line_fill_if.slave bus
);
    // LINE_BYTES must be a multiple of 4 so the line is a whole number of beats.
    localparam int                LINE_BYTES = NUM_BLOCKS * BLOCK_SIZE;
    localparam int                BEATS      = LINE_BYTES / 4;
    localparam int                LINE_W     = 8 * LINE_BYTES;
    localparam int                BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0]       OFF_MASK   = 32'(LINE_BYTES - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [BEAT_W-1:0] beat_q,       beat_d;
    logic              mem_valid_q,  mem_valid_d;
    logic [31:0]       mem_addr_q,   mem_addr_d;
    logic              line_ready_q, line_ready_d;
    logic [LINE_W-1:0] line_rdata_q, line_rdata_d;

    logic [31:0]       req_base;
    logic              buf_hit;
    logic [LINE_W-1:0] hit_data;

    // Offset bits of the request address are dropped: fills are line aligned.
    assign req_base = bus.line_addr & ~OFF_MASK;

`ifdef ICACHE_LINE_FILL_BUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [31:0]       buf_tag_q,   buf_tag_d;
    logic [LINE_W-1:0] buf_data_q,  buf_data_d;

    assign buf_hit  = buf_valid_q && (buf_tag_q == req_base);
    assign hit_data = buf_data_q;

    // Capture the line only when a fill runs to completion; aborts leave it alone.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        if ((state_q == S_FETCH) && bus.mem_ready && bus.line_valid &&
            (beat_q == BEAT_LAST)) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = mem_addr_q & ~OFF_MASK;
            buf_data_d  = line_rdata_d;
        end
    end

    // Last-line buffer registers; reset invalidates the entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign hit_data = '0;
`endif

    // Fill sequencer: request acceptance, per-beat word capture, abort and completion.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        line_ready_d = 1'b0;
        line_rdata_d = line_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.line_valid) begin
                    if (buf_hit) begin
                        state_d      = S_DONE;
                        line_ready_d = 1'b1;
                        line_rdata_d = hit_data;
                    end else begin
                        state_d     = S_FETCH;
                        beat_d      = '0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = req_base;
                    end
                end
            end

            S_FETCH: begin
                // mem_valid stays high through wait cycles until the word arrives.
                if (bus.mem_ready) begin
                    line_rdata_d[32*int'(beat_q) +: 32] = bus.mem_rdata;
                    if (!bus.line_valid) begin
                        // Requester gave up: keep the word just read, skip the rest.
                        state_d     = S_IDLE;
                        beat_d      = '0;
                        mem_valid_d = 1'b0;
                    end else if (beat_q == BEAT_LAST) begin
                        state_d      = S_DONE;
                        beat_d       = '0;
                        mem_valid_d  = 1'b0;
                        line_ready_d = 1'b1;
                    end else begin
                        beat_d     = beat_q + BEAT_W'(1);
                        mem_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d     = S_IDLE;
                beat_d      = '0;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset clears every output mid-fill as well.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            line_ready_q <= 1'b0;
            line_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            line_ready_q <= line_ready_d;
            line_rdata_q <= line_rdata_d;
        end
    end

    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.line_ready = line_ready_q;
    assign bus.line_rdata = line_rdata_q;
endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: a default-size instance (2 beats) exercised
// by a directed vector table, hand-written abort/reset/spurious sequences
// and randomized memory timing against a line-level reference model, plus
// an 8x2 instance (4 beats) for the wider line.
module tb_icache_line_fill;
`ifdef ICACHE_LINE_FILL_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif
    localparam int BEATS_A = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    icache_line_fill_if #(.LINE_BYTES(8))  bus_a ();
    icache_line_fill_if #(.LINE_BYTES(16)) bus_b ();

    icache_line_fill #(.NUM_BLOCKS(4), .BLOCK_SIZE(2)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_a.slave)
    );

    icache_line_fill #(.NUM_BLOCKS(8), .BLOCK_SIZE(2)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_b.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          memcyc_a  = 0;
    int          waits_a   = 0;
    int          wcnt_a    = 0;
    int          wait_cfg  = 0;
    bit          rand_mode = 1'b0;
    bit          spur      = 1'b0;
    logic [31:0] addrq_a[$];
    logic [31:0] addrq_b[$];

    // reference model: last completed line (only consulted when the buffer exists)
    bit          mdl_valid = 1'b0;
    logic [31:0] mdl_base  = '0;
    logic [63:0] mdl_data  = '0;

    typedef struct {
        logic [31:0] addr;
        int          waits;
        int          exp_lat;
        logic [63:0] exp_data;
        int          exp_mem;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h1111_1111;
        if (a == 32'h0000_1004) return 32'h2222_2222;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit addrs_ok(input logic [31:0] base, input int n);
        if (addrq_a.size() != n) return 1'b0;
        for (int k = 0; k < n; k++)
            if (addrq_a[k] !== base + 32'(4 * k)) return 1'b0;
        return 1'b1;
    endfunction

    // memory model for instance A: fixed or random wait states per beat
    always @(negedge clk) begin
        if (!resetn) begin
            bus_a.mem_ready = 1'b0;
            bus_a.mem_rdata = '0;
            wcnt_a          = 0;
        end else if (bus_a.mem_valid) begin
            bit rdy;
            memcyc_a++;
            if (rand_mode) rdy = ($urandom_range(0, 2) == 0);
            else           rdy = (wcnt_a >= wait_cfg);
            if (rdy) begin
                bus_a.mem_ready = 1'b1;
                bus_a.mem_rdata = memword(bus_a.mem_addr);
                addrq_a.push_back(bus_a.mem_addr);
                wcnt_a = 0;
            end else begin
                bus_a.mem_ready = 1'b0;
                bus_a.mem_rdata = 32'hDEAD_BEEF;
                wcnt_a++;
                waits_a++;
            end
        end else begin
            bus_a.mem_ready = spur;
            bus_a.mem_rdata = spur ? 32'hBAD0_BAD0 : 32'h0;
            wcnt_a          = 0;
        end
    end

    // zero-wait memory model for instance B
    always @(negedge clk) begin
        if (!resetn || !bus_b.mem_valid) begin
            bus_b.mem_ready = 1'b0;
            bus_b.mem_rdata = '0;
        end else begin
            bus_b.mem_ready = 1'b1;
            bus_b.mem_rdata = memword(bus_b.mem_addr);
            addrq_b.push_back(bus_b.mem_addr);
        end
    end

    // Issue one request on A (called #1 after a rising edge, DUT idle) and
    // measure cycles from the acceptance edge to line_ready.
    task automatic run_a(input logic [31:0] addr, input int w,
                         output int lat, output logic [63:0] data, output bit got);
        wait_cfg = w;
        memcyc_a = 0;
        waits_a  = 0;
        addrq_a.delete();
        bus_a.line_valid = 1'b1;
        bus_a.line_addr  = addr;
        @(posedge clk);
        #1;
        bus_a.line_addr = $urandom();
        lat = 1;
        while (!bus_a.line_ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got  = bus_a.line_ready;
        data = bus_a.line_rdata;
        bus_a.line_valid = 1'b0;
        @(posedge clk);
        #1;
        if (got) check("line_ready_width", {127'b0, bus_a.line_ready}, 128'd0);
    endtask

    task automatic model_req(input logic [31:0] addr, input int w, input string tag);
        int          lat;
        logic [63:0] data;
        bit          got;
        logic [31:0] base;
        bit          hit;
        logic [63:0] exp_data;
        int          exp_lat;
        run_a(addr, w, lat, data, got);
        base     = addr & ~32'h7;
        hit      = BUF_EN && mdl_valid && (mdl_base == base);
        exp_data = hit ? mdl_data : {memword(base + 32'd4), memword(base)};
        exp_lat  = hit ? 1 : BEATS_A + waits_a + 1;
        check({tag, "_ready"}, {127'b0, got}, 128'd1);
        check({tag, "_lat"},   128'(lat), 128'(exp_lat));
        check({tag, "_data"},  {64'b0, data}, {64'b0, exp_data});
        check({tag, "_addrs"}, {127'b0, addrs_ok(base, hit ? 0 : BEATS_A)}, 128'd1);
        mdl_valid = 1'b1;
        mdl_base  = base;
        mdl_data  = exp_data;
    endtask

    initial begin
        int          lat;
        logic [63:0] data;
        bit          got;
        bit          seen;

        vecs[0] = '{32'h0000_1006, 0, 3, 64'h2222_2222_1111_1111, 2};
        vecs[1] = '{32'h0000_3000, 2, 7, {memword(32'h3004), memword(32'h3000)}, 6};
        vecs[2] = '{32'h0000_2000, 0, 3, {memword(32'h2004), memword(32'h2000)}, 2};
        vecs[3] = '{32'h0000_2000, 0, BUF_EN ? 1 : 3, {memword(32'h2004), memword(32'h2000)}, BUF_EN ? 0 : 2};
        vecs[4] = '{32'h0000_2005, 1, BUF_EN ? 1 : 5, {memword(32'h2004), memword(32'h2000)}, BUF_EN ? 0 : 4};
        vecs[5] = '{32'h0000_1000, 0, 3, 64'h2222_2222_1111_1111, 2};

        bus_a.line_valid = 1'b0;
        bus_a.line_addr  = '0;
        bus_b.line_valid = 1'b0;
        bus_b.line_addr  = '0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_valid",  {127'b0, bus_a.mem_valid},  128'd0);
        check("rst_line_ready", {127'b0, bus_a.line_ready}, 128'd0);
        check("rst_mem_addr",   128'(bus_a.mem_addr),       128'd0);
        check("rst_line_rdata", 128'(bus_a.line_rdata),     128'd0);
        check("rst_b_rdata",    bus_b.line_rdata,           128'd0);
        resetn = 1'b1;

        // no request is taken while line_valid stays low after reset
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("idle_no_fetch", {127'b0, bus_a.mem_valid}, 128'd0);
        end

        // stray mem_ready while idle must not disturb anything
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        @(posedge clk);
        #1;
        check("spur_mem_valid",  {127'b0, bus_a.mem_valid},  128'd0);
        check("spur_line_ready", {127'b0, bus_a.line_ready}, 128'd0);
        check("spur_rdata",      128'(bus_a.line_rdata),     128'd0);

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            run_a(vecs[i].addr, vecs[i].waits, lat, data, got);
            check($sformatf("vec%0d_ready", i),  {127'b0, got}, 128'd1);
            check($sformatf("vec%0d_lat", i),    128'(lat), 128'(vecs[i].exp_lat));
            check($sformatf("vec%0d_data", i),   {64'b0, data}, {64'b0, vecs[i].exp_data});
            check($sformatf("vec%0d_memcyc", i), 128'(memcyc_a), 128'(vecs[i].exp_mem));
            check($sformatf("vec%0d_addrs", i),
                  {127'b0, addrs_ok(vecs[i].addr & ~32'h7, vecs[i].exp_mem == 0 ? 0 : BEATS_A)}, 128'd1);
            mdl_valid = 1'b1;
            mdl_base  = vecs[i].addr & ~32'h7;
            mdl_data  = vecs[i].exp_data;
        end

        // abort: line_valid drops while beat 0 is in flight
        wait_cfg = 0;
        memcyc_a = 0;
        waits_a  = 0;
        addrq_a.delete();
        bus_a.line_valid = 1'b1;
        bus_a.line_addr  = 32'h0000_4000;
        @(posedge clk);
        #1;
        check("abort_mem_valid", {127'b0, bus_a.mem_valid}, 128'd1);
        check("abort_mem_addr",  128'(bus_a.mem_addr), 128'h4000);
        bus_a.line_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen |= bus_a.line_ready;
        end
        check("abort_no_ready", {127'b0, seen}, 128'd0);
        check("abort_memcyc",   128'(memcyc_a), 128'd1);
        check("abort_addrs",    {127'b0, addrs_ok(32'h4000, 1)}, 128'd1);
        check("abort_hold",     128'(bus_a.line_rdata), {64'b0, 32'h2222_2222, memword(32'h4000)});
        model_req(32'h0000_4000, 0, "after_abort");

        // reset in the middle of a fill
        wait_cfg = 3;
        bus_a.line_valid = 1'b1;
        bus_a.line_addr  = 32'h0000_5000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        check("midrst_pre_valid", {127'b0, bus_a.mem_valid}, 128'd1);
        resetn = 1'b0;
        #1;
        check("midrst_mem_valid",  {127'b0, bus_a.mem_valid},  128'd0);
        check("midrst_line_ready", {127'b0, bus_a.line_ready}, 128'd0);
        check("midrst_mem_addr",   128'(bus_a.mem_addr),       128'd0);
        check("midrst_rdata",      128'(bus_a.line_rdata),     128'd0);
        bus_a.line_valid = 1'b0;
        mdl_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_req(32'h0000_4000, 0, "post_rst1");
        model_req(32'h0000_4003, 0, "post_rst2");

        // 8 blocks x 2 bytes: four beats, ascending order
        addrq_b.delete();
        bus_b.line_valid = 1'b1;
        bus_b.line_addr  = 32'h0000_6004;
        @(posedge clk);
        #1;
        bus_b.line_addr = 32'hFFFF_FFF0;
        lat = 1;
        while (!bus_b.line_ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("wide_ready", {127'b0, bus_b.line_ready}, 128'd1);
        check("wide_lat",   128'(lat), 128'd5);
        check("wide_data",  bus_b.line_rdata,
              {memword(32'h600C), memword(32'h6008), memword(32'h6004), memword(32'h6000)});
        check("wide_nbeats", 128'(addrq_b.size()), 128'd4);
        if (addrq_b.size() == 4)
            for (int k = 0; k < 4; k++)
                check($sformatf("wide_addr%0d", k), 128'(addrq_b[k]), 128'(32'h6000 + 32'(4 * k)));
        bus_b.line_valid = 1'b0;
        @(posedge clk);
        #1;

        // randomized memory timing over a few lines
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = 32'h0000_7000 + 32'($urandom_range(0, 2)) * 32'd8 + 32'($urandom_range(0, 7));
            model_req(a, 0, $sformatf("rnd%0d", i));
        end
        rand_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
